// File: rtl/riscv_imm_pkg.sv
// Shared definitions for the immediate-generation decode slice.
//   immsrc_t : encoding of the immediate class carried on in_immsrc.
//   xlen_ok  : legality check for the XLEN parameter (32 or 64 only).
package riscv_imm_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_BAD = 3'b111
  } immsrc_t;

  localparam int XLEN_NARROW = 32;
  localparam int XLEN_WIDE   = 64;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == XLEN_NARROW) || (xlen == XLEN_WIDE);
  endfunction

endpackage

// File: rtl/imm_format.sv
// Combinational immediate formatter.
//   instr_i   : instruction bits [31:7] (opcode field is never needed)
//   immsrc_i  : immediate class
//   imm_o     : immediate sign/zero-extended to XLEN
//   illegal_o : class 3'b111, immediate forced to zero
module imm_format
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr_i,
  input  immsrc_t         immsrc_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] sgn;

  assign sgn = {XLEN{instr_i[31]}};

  // Each class starts from the fully sign-extended (or zero) word and then
  // overwrites the low-order field bits, which keeps the XLEN=32/64 cases
  // identical apart from the shift amount width.
  always_comb begin
    imm_o     = '0;
    illegal_o = 1'b0;
    case (immsrc_i)
      IMM_I: begin
        imm_o       = sgn;
        imm_o[11:0] = instr_i[31:20];
      end
      IMM_S: begin
        imm_o       = sgn;
        imm_o[11:5] = instr_i[31:25];
        imm_o[4:0]  = instr_i[11:7];
      end
      IMM_B: begin
        imm_o       = sgn;
        imm_o[11]   = instr_i[7];
        imm_o[10:5] = instr_i[30:25];
        imm_o[4:1]  = instr_i[11:8];
        imm_o[0]    = 1'b0;
      end
      IMM_J: begin
        imm_o        = sgn;
        imm_o[19:12] = instr_i[19:12];
        imm_o[11]    = instr_i[20];
        imm_o[10:1]  = instr_i[30:21];
        imm_o[0]     = 1'b0;
      end
      IMM_U: begin
        imm_o        = sgn;
        imm_o[31:12] = instr_i[31:12];
        imm_o[11:0]  = 12'b0;
      end
      IMM_Z: begin
        imm_o[4:0] = instr_i[19:15];
      end
      IMM_SH: begin
        // RV64 shifts take a 6-bit shamt; RV32 keeps bit 25 out of it.
        if (XLEN == 64) imm_o[5:0] = instr_i[25:20];
        else            imm_o[4:0] = instr_i[24:20];
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate-generation decode stage with 1-cycle latency and a 2-entry
// (output register + skid register) elastic buffer.
//   clk, reset (sync, active-high), flush (sync squash of held entries)
//   in_valid/in_ready, in_instr, in_immsrc, in_tag : upstream entry
//   out_valid/out_ready, out_imm, out_tag, out_illegal : downstream entry
// in_ready is taken straight from the skid-valid flop, so it never depends
// combinationally on out_ready.
module imm_decode_stage
  import riscv_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  if (!xlen_ok(XLEN)) begin : g_xlen_bad
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] fmt_imm;
  logic            fmt_illegal;
  logic            unused_opcode;

  assign unused_opcode = ^in_instr[6:0];

  imm_format #(.XLEN(XLEN)) u_fmt (
    .instr_i   (in_instr[31:7]),
    .immsrc_i  (immsrc_t'(in_immsrc)),
    .imm_o     (fmt_imm),
    .illegal_o (fmt_illegal)
  );

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_illegal_q, out_illegal_d;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_illegal_q, skid_illegal_d;

  logic in_fire;

  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_imm_d      = out_imm_q;
    out_tag_d      = out_tag_q;
    out_illegal_d  = out_illegal_q;
    skid_valid_d   = skid_valid_q;
    skid_imm_d     = skid_imm_q;
    skid_tag_d     = skid_tag_q;
    skid_illegal_d = skid_illegal_q;

    if (!out_valid_q || out_ready) begin
      // Output slot frees up: the older skid entry goes first to keep FIFO
      // order. in_ready is low whenever skid is valid, so no input competes.
      if (skid_valid_q) begin
        out_valid_d   = 1'b1;
        out_imm_d     = skid_imm_q;
        out_tag_d     = skid_tag_q;
        out_illegal_d = skid_illegal_q;
        skid_valid_d  = 1'b0;
      end else if (in_fire) begin
        out_valid_d   = 1'b1;
        out_imm_d     = fmt_imm;
        out_tag_d     = in_tag;
        out_illegal_d = fmt_illegal;
      end else begin
        out_valid_d   = 1'b0;
      end
    end else if (in_fire) begin
      // Output stalled: park the accepted entry in skid.
      skid_valid_d   = 1'b1;
      skid_imm_d     = fmt_imm;
      skid_tag_d     = in_tag;
      skid_illegal_d = fmt_illegal;
    end

    // Flush only kills the valid bits; data registers may keep stale values.
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_imm_q     <= '0;
      out_tag_q     <= '0;
      out_illegal_q <= 1'b0;
      skid_valid_q  <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_imm_q     <= out_imm_d;
      out_tag_q     <= out_tag_d;
      out_illegal_q <= out_illegal_d;
      skid_valid_q  <= skid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_imm_q     <= skid_imm_d;
    skid_tag_q     <= skid_tag_d;
    skid_illegal_q <= skid_illegal_d;
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush;
  logic [31:0] instr;
  logic [2:0]  immsrc;
  logic [31:0] tag;
  logic        v32, v64, ordy32, ordy64;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32, otag32;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64;
  logic [31:0] otag64;

  imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(v32), .in_ready(rdy32), .in_instr(instr), .in_immsrc(immsrc),
    .in_tag(tag), .out_valid(ov32), .out_ready(ordy32), .out_imm(imm32),
    .out_tag(otag32), .out_illegal(ill32)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(v64), .in_ready(rdy64), .in_instr(instr), .in_immsrc(immsrc),
    .in_tag(tag), .out_valid(ov64), .out_ready(ordy64), .out_imm(imm64),
    .out_tag(otag64), .out_illegal(ill64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  logic [63:0] cur_imm;
  logic        cur_ill;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitors: pop on every output handshake, check hold while
  // stalled, then record newly accepted inputs (dropped on flush/reset).
  bit          st32 = 0, st64 = 0;
  logic [63:0] h_imm32, h_imm64;
  logic [31:0] h_tag32, h_tag64;
  logic        h_ill32, h_ill64;

  always @(negedge clk) begin
    exp_t e;
    if (st32) begin
      chk("hold32_valid", 64'(ov32), 64'd1);
      chk("hold32_imm", 64'(imm32), h_imm32);
      chk("hold32_tag", 64'(otag32), 64'(h_tag32));
      chk("hold32_ill", 64'(ill32), 64'(h_ill32));
    end
    st32 = ov32 && !ordy32 && !flush && !reset;
    h_imm32 = 64'(imm32); h_tag32 = otag32; h_ill32 = ill32;
    if (ov32 === 1'b1 && ordy32) begin
      if (q32.size() == 0) chk("unexpected_out32_tag", 64'(otag32), 64'hDEAD_0000);
      else begin
        e = q32.pop_front();
        chk("out32_imm", 64'(imm32), {32'h0, e.imm[31:0]});
        chk("out32_tag", 64'(otag32), 64'(e.tag));
        chk("out32_ill", 64'(ill32), 64'(e.ill));
      end
    end
    if (reset || flush) q32.delete();
    else if (v32 && rdy32) q32.push_back('{cur_imm, tag, cur_ill});
  end

  always @(negedge clk) begin
    exp_t e;
    if (st64) begin
      chk("hold64_valid", 64'(ov64), 64'd1);
      chk("hold64_imm", imm64, h_imm64);
      chk("hold64_tag", 64'(otag64), 64'(h_tag64));
      chk("hold64_ill", 64'(ill64), 64'(h_ill64));
    end
    st64 = ov64 && !ordy64 && !flush && !reset;
    h_imm64 = imm64; h_tag64 = otag64; h_ill64 = ill64;
    if (ov64 === 1'b1 && ordy64) begin
      if (q64.size() == 0) chk("unexpected_out64_tag", 64'(otag64), 64'hDEAD_0000);
      else begin
        e = q64.pop_front();
        chk("out64_imm", imm64, e.imm);
        chk("out64_tag", 64'(otag64), 64'(e.tag));
        chk("out64_ill", 64'(ill64), 64'(e.ill));
      end
    end
    if (reset || flush) q64.delete();
    else if (v64 && rdy64) q64.push_back('{cur_imm, tag, cur_ill});
  end

  // Present one entry, hold it until the selected DUT accepts it, and return
  // 1 time unit after the accepting edge.
  task automatic send(input bit sel64, input logic [31:0] ins, input logic [2:0] src,
                      input logic [31:0] tg, input logic [63:0] ei, input bit eill);
    bit ok;
    instr = ins; immsrc = src; tag = tg; cur_imm = ei; cur_ill = eill;
    if (sel64) v64 = 1'b1; else v32 = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = sel64 ? rdy64 : rdy32;
    end
    if (!ok) chk("send_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; v32 = 1'b0; v64 = 1'b0;
    ordy32 = 1'b1; ordy64 = 1'b1;
    instr = '0; immsrc = '0; tag = '0; cur_imm = '0; cur_ill = 1'b0;
    idle(2);
    chk("rst_out_valid", 64'(ov32), 64'd0);
    chk("rst_in_ready", 64'(rdy32), 64'd1);
    chk("rst_out_imm", 64'(imm32), 64'd0);
    chk("rst_out_tag", 64'(otag32), 64'd0);
    chk("rst_out_ill", 64'(ill32), 64'd0);
    reset = 1'b0;
    idle(1);

    // XLEN=32 formatting, back to back
    send(0, 32'hFFF00093, 3'b000, 32'h100, 64'hFFFF_FFFF, 0);
    chk("lat1_valid", 64'(ov32), 64'd1);
    chk("lat1_imm", 64'(imm32), 64'hFFFF_FFFF);
    send(0, 32'hFE20AE23, 3'b001, 32'h104, 64'hFFFF_FFFC, 0);
    send(0, 32'hFE000CE3, 3'b010, 32'h108, 64'hFFFF_FFF8, 0);
    send(0, 32'h123450B7, 3'b100, 32'h10C, 64'h1234_5000, 0);
    idle(3);

    // XLEN=64 formatting
    send(1, 32'h800000B7, 3'b100, 32'h200, 64'hFFFF_FFFF_8000_0000, 0);
    send(1, 32'h01F00013, 3'b110, 32'h204, 64'h1F, 0);
    send(1, 32'hFFF7D073, 3'b101, 32'h208, 64'h0F, 0);
    send(1, 32'hFFF00093, 3'b000, 32'h20C, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    idle(3);

    // Illegal class followed by a normal entry
    send(0, 32'hFFFFFFFF, 3'b111, 32'h300, 64'h0, 1);
    chk("illegal_flag", 64'(ill32), 64'd1);
    chk("illegal_imm", 64'(imm32), 64'd0);
    send(0, 32'h00500093, 3'b000, 32'h304, 64'h5, 0);
    chk("after_illegal_flag", 64'(ill32), 64'd0);
    chk("after_illegal_imm", 64'(imm32), 64'd5);
    idle(3);

    // Back-pressure: tags 1..6, out_ready low for three cycles
    fork
      begin
        for (int t = 1; t <= 6; t++)
          send(0, {12'(t), 20'h00093}, 3'b000, 32'(t), 64'(t), 0);
      end
      begin
        @(posedge clk); #1;
        ordy32 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("bp_in_ready_low", 64'(rdy32), 64'd0);
        @(posedge clk); #1;
        ordy32 = 1'b1;
      end
    join
    idle(4);
    chk("bp_drained", 64'(q32.size()), 64'd0);

    // Flush with output and skid full while in_valid is high
    ordy32 = 1'b0;
    send(0, 32'h00100093, 3'b000, 32'h20, 64'h1, 0);
    send(0, 32'h00200093, 3'b000, 32'h21, 64'h2, 0);
    chk("full_in_ready_low", 64'(rdy32), 64'd0);
    instr = 32'h00300093; immsrc = 3'b000; tag = 32'h22; cur_imm = 64'h3;
    v32 = 1'b1; flush = 1'b1;
    idle(1);
    flush = 1'b0; v32 = 1'b0;
    chk("flush_out_valid", 64'(ov32), 64'd0);
    chk("flush_in_ready", 64'(rdy32), 64'd1);
    ordy32 = 1'b1;
    // An accepted input in the flush cycle is discarded as well
    instr = 32'h00400093; tag = 32'h23; cur_imm = 64'h4;
    v32 = 1'b1; flush = 1'b1;
    idle(1);
    flush = 1'b0; v32 = 1'b0;
    chk("flush_fire_dropped", 64'(ov32), 64'd0);
    idle(3);

    // Reset in the middle of a stall with skid full
    ordy32 = 1'b0;
    send(0, 32'h00100093, 3'b000, 32'h30, 64'h1, 0);
    send(0, 32'h00200093, 3'b000, 32'h31, 64'h2, 0);
    reset = 1'b1; flush = 1'b1;
    idle(1);
    reset = 1'b0; flush = 1'b0;
    chk("mid_rst_out_valid", 64'(ov32), 64'd0);
    chk("mid_rst_in_ready", 64'(rdy32), 64'd1);
    chk("mid_rst_imm", 64'(imm32), 64'd0);
    chk("mid_rst_tag", 64'(otag32), 64'd0);
    chk("mid_rst_ill", 64'(ill32), 64'd0);
    ordy32 = 1'b1;
    send(0, 32'hFE20AE23, 3'b001, 32'h40, 64'hFFFF_FFFC, 0);
    send(0, 32'h00700093, 3'b000, 32'h44, 64'h7, 0);
    idle(4);

    chk("q32_empty", 64'(q32.size()), 64'd0);
    chk("q64_empty", 64'(q64.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Parametrised immediate-generation stage for the decode slice of the pipelined RISC-V core. It formats the immediate for every base-ISA immediate class (I, S, B, J, U, CSR-zimm, shamt), sign- or zero-extends it to XLEN, and registers the result with a tag. It sits between fetch/decode and the issue/execute register. A valid/ready handshake with a 2-entry skid buffer provides back-pressure, plus a synchronous flush for branch redirects.

## Interface
- XLEN, 32: result width; 32 or 64 only.
- TAG_W, 32: width of the pass-through tag (normally the PC).
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  input entry present.
- in_ready  out  1  stage can accept; equals !skid_valid.
- in_instr  in  32  raw instruction; bits [6:0] ignored.
- in_immsrc  in  3  immediate class (see Operation).
- in_tag  in  TAG_W  carried unchanged to the output.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the output entry.
- out_illegal  out  1  immsrc was 3'b111.

## Operation
- Immediate classes (in_immsrc), with S = instr[31] replicated to XLEN:
  - 000 I: S, instr[31:20].
  - 001 S: S, instr[31:25], instr[11:7].
  - 010 B: S, instr[7], instr[30:25], instr[11:8], 0.
  - 011 J: S, instr[19:12], instr[20], instr[30:21], 0.
  - 100 U: S above bit 31, instr[31:12], 12'b0. For XLEN=64, bits 63:32 are copies of instr[31].
  - 101 Z: zero-extended instr[19:15].
  - 110 SH: zero-extended instr[24:20] for XLEN=32; instr[25:20] for XLEN=64.
  - 111: imm = 0, illegal = 1. Not an error stop; the entry flows normally.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Output register update, when !out_valid or out_fire:
  - if skid_valid: load from skid and clear skid;
  - else if in_fire: load the formatted input;
  - else: clear out_valid.
- Stall path, when out_valid and !out_ready: an in_fire entry is written to skid. Skid is never overwritten while valid, because in_ready is low.
- Ordering is strictly FIFO. No entry is dropped or duplicated except by flush or reset.
- Flush has priority over every update above:
  - out_valid and skid_valid clear next cycle;
  - an in_fire in the flush cycle is discarded;
  - the out_imm/out_tag data registers may hold stale values.
- Reset: out_valid=0, skid_valid=0, out_imm=0, out_tag=0, out_illegal=0. After reset, in_ready=1.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears on out_* after edge N with out_valid=1 when the output was free.
- Sustains 1 entry/cycle while out_ready=1.
- in_ready is a register output, with no combinational path from out_ready.
- After a single-cycle stall, one entry sits in skid and in_ready is low for exactly one cycle once out_ready returns.
- out_* are stable while out_valid & !out_ready.
- Reset during a stall empties both entries in the same edge. Reset dominates flush.

## Structure
- Package riscv_imm_pkg:
  - immsrc_t enum with IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SH, IMM_BAD;
  - XLEN legality check constant.
- Sub-module imm_format (combinational, parameter XLEN): instr, immsrc → imm, illegal. It is instantiated once on the input path.
- Top level holds the output register, the skid register and the control.

## Test plan
- XLEN=32 formatting, one per cycle, out_ready=1. Each result must appear 1 cycle later:
  - 0xFFF00093 I → 0xFFFFFFFF;
  - 0xFE20AE23 S → 0xFFFFFFFC;
  - 0xFE000CE3 B → 0xFFFFFFF8;
  - 0x123450B7 U → 0x12345000.
- XLEN=64:
  - 0x800000B7 U → 0xFFFFFFFF80000000;
  - 0x01F00013 SH → 0x1F;
  - 0xFFF7D073 Z → 0x0000000F.
- Back-pressure: stream tags 1..6 with out_ready low for cycles 2–4.
  - in_ready drops after the skid fills.
  - Output order is exactly 1..6, with no loss or duplication.
  - out_* are held stable while stalled.
- Flush with both entries full and in_valid=1: out_valid=0 next cycle, in_ready=1, and the flushed input never appears.
- immsrc=111 on 0xFFFFFFFF: out_imm=0 and out_illegal=1. The next entry (I, 0x00500093) gives out_imm=5 and out_illegal=0.
- Reset asserted mid-stall with skid full: next cycle out_valid=0, in_ready=1 and all outputs are zero. Traffic after reset is correct.
